// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: 1:4 TDM receive demux with sync lock and miss flywheel.
// Optional TDM_PARITY_EN: a fifth XOR-parity slot gates frame delivery.
module tdm_demux_4ch #(
  parameter int WIDTH      = 1,
  parameter int MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic [1:0]       sel,
  output logic             locked,
  output logic             sync_err,
  output logic             parity_err
);

`ifdef TDM_PARITY_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif

  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t          state;
  logic [2:0]      slot;
  logic [MW-1:0]   miss;
  logic [MW-1:0]   miss_nxt;
  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic [WIDTH-1:0] sh2;

`ifdef TDM_PARITY_EN
  logic [WIDTH-1:0] sh3;
  logic [WIDTH-1:0] par;
  logic             perr;

  assign par        = sh0 ^ sh1 ^ sh2 ^ sh3;
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif

  // The parity slot (index 4) reads back as sel=0 on the 2-bit port.
  assign sel      = slot[1:0];
  assign miss_nxt = miss + 1'b1;

  // Lock FSM, slot counter, shadow capture and frame publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= 3'd0;
      miss        <= '0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      ch0         <= '0;
      ch1         <= '0;
      ch2         <= '0;
      ch3         <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
      sh3         <= '0;
      perr        <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
      perr        <= 1'b0;
`endif
      if (din_valid) begin
        unique case (state)
          HUNT: begin
            if (sync) begin
              sh0    <= din;
              slot   <= 3'd1;
              miss   <= '0;
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (sync && slot != 3'd0) begin
              // Early marker: drop the partial frame, restart at slot 0.
              sync_err <= 1'b1;
              sh0      <= din;
              slot     <= 3'd1;
              miss     <= '0;
            end else if (slot == 3'd0) begin
              if (sync) begin
                sh0  <= din;
                slot <= 3'd1;
                miss <= '0;
              end else begin
                sync_err <= 1'b1;
                if (miss_nxt >= MISS_MAX) begin
                  state  <= HUNT;
                  locked <= 1'b0;
                  slot   <= 3'd0;
                  miss   <= '0;
                end else begin
                  // Flywheel: trust the slot count for this frame.
                  miss <= miss_nxt;
                  sh0  <= din;
                  slot <= 3'd1;
                end
              end
            end else if (slot == LAST) begin
`ifdef TDM_PARITY_EN
              if (din == par) begin
                ch0         <= sh0;
                ch1         <= sh1;
                ch2         <= sh2;
                ch3         <= sh3;
                frame_valid <= 1'b1;
              end else begin
                perr <= 1'b1;
              end
`else
              ch0         <= sh0;
              ch1         <= sh1;
              ch2         <= sh2;
              ch3         <= din;
              frame_valid <= 1'b1;
`endif
              slot <= 3'd0;
            end else begin
              unique case (slot)
                3'd1:    sh1 <= din;
`ifdef TDM_PARITY_EN
                3'd2:    sh2 <= din;
                default: sh3 <= din;
`else
                default: sh2 <= din;
`endif
              endcase
              slot <= slot + 3'd1;
            end
          end
          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: directed-vector bench for tdm_demux_4ch.
// WIDTH=4, MISS_LIMIT=2.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] ch0, ch1, ch2, ch3;
  logic       frame_valid;
  logic [1:0] sel;
  logic       locked;
  logic       sync_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdm_demux_4ch #(
    .WIDTH(4),
    .MISS_LIMIT(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .sync(sync),
    .ch0(ch0),
    .ch1(ch1),
    .ch2(ch2),
    .ch3(ch3),
    .frame_valid(frame_valid),
    .sel(sel),
    .locked(locked),
    .sync_err(sync_err),
    .parity_err(parity_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Drive one beat; on return the posedge has sampled it.
  task automatic beat(input logic s, input logic [3:0] d, input logic v);
    sync = s;
    din = d;
    din_valid = v;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    din_valid = 1'b0;
    sync = 1'b0;
    din = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    din = 4'd1;
    sync = 1'b1;
    din_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ch0, ch1, ch2, ch3} !== 16'h0) begin
      errors++;
      $display("FAIL reset_ch: got %h expected 0000", {ch0, ch1, ch2, ch3});
    end
    checks++;
    if ({frame_valid, locked, sync_err, parity_err, sel} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {frame_valid, locked, sync_err, parity_err, sel});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (locked !== 1'b1 || sel !== 2'd1) begin
      errors++;
      $display("FAIL reset_release: locked=%b sel=%0d expected 1/1", locked, sel);
    end
    din_valid = 1'b0;
    sync = 1'b0;
  endtask

`ifndef TDM_PARITY_EN
  task automatic test_normal;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat(i == 0, 4'(i + 1), 1'b1);
      checks++;
      if (frame_valid !== (i == 3)) begin
        errors++;
        $display("FAIL normal_fv beat %0d: got %b expected %b", i, frame_valid, i == 3);
      end
    end
    checks++;
    if ({ch0, ch1, ch2, ch3} !== 16'h1234) begin
      errors++;
      $display("FAIL normal_ch: got %h expected 1234", {ch0, ch1, ch2, ch3});
    end
    beat(1'b0, 4'd0, 1'b0);
    checks++;
    if (frame_valid !== 1'b0 || {ch0, ch1, ch2, ch3} !== 16'h1234) begin
      errors++;
      $display("FAIL normal_hold: fv=%b ch=%h expected 0/1234",
               frame_valid, {ch0, ch1, ch2, ch3});
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] v [12];
    v = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
          4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd1};
    do_reset();
    for (int b = 0; b < 12; b++) begin
      beat(b % 4 == 0, v[b], 1'b1);
      checks++;
      if (frame_valid !== (b % 4 == 3) || sel !== 2'((b + 1) % 4)) begin
        errors++;
        $display("FAIL b2b_beat %0d: fv=%b sel=%0d expected %b/%0d",
                 b, frame_valid, sel, b % 4 == 3, (b + 1) % 4);
      end
      if (b % 4 == 3) begin
        checks++;
        if ({ch0, ch1, ch2, ch3} !== {v[b-3], v[b-2], v[b-1], v[b]}) begin
          errors++;
          $display("FAIL b2b_ch %0d: got %h expected %h", b,
                   {ch0, ch1, ch2, ch3}, {v[b-3], v[b-2], v[b-1], v[b]});
        end
      end
    end
  endtask

  task automatic test_stalls;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat(i == 0, 4'(i + 1), 1'b1);
      checks++;
      if (frame_valid !== (i == 3) || sel !== 2'((i + 1) % 4)) begin
        errors++;
        $display("FAIL stall_beat %0d: fv=%b sel=%0d expected %b/%0d",
                 i, frame_valid, sel, i == 3, (i + 1) % 4);
      end
      if (i < 3) begin
        beat(1'b1, 4'd15, 1'b0);
        checks++;
        if (frame_valid !== 1'b0 || sel !== 2'(i + 1) || sync_err !== 1'b0) begin
          errors++;
          $display("FAIL stall_idle %0d: fv=%b sel=%0d serr=%b expected 0/%0d/0",
                   i, frame_valid, sel, sync_err, i + 1);
        end
      end
    end
    checks++;
    if ({ch0, ch1, ch2, ch3} !== 16'h1234) begin
      errors++;
      $display("FAIL stall_ch: got %h expected 1234", {ch0, ch1, ch2, ch3});
    end
  endtask

  task automatic test_early_sync;
    do_reset();
    beat(1'b1, 4'd1, 1'b1);
    beat(1'b0, 4'd2, 1'b1);
    beat(1'b0, 4'd3, 1'b1);
    beat(1'b0, 4'd4, 1'b1);
    beat(1'b1, 4'd9, 1'b1);
    beat(1'b0, 4'd10, 1'b1);
    beat(1'b1, 4'd11, 1'b1);
    checks++;
    if (sync_err !== 1'b1 || frame_valid !== 1'b0 || sel !== 2'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL early_pulse: serr=%b fv=%b sel=%0d lk=%b expected 1/0/1/1",
               sync_err, frame_valid, sel, locked);
    end
    beat(1'b0, 4'd5, 1'b1);
    beat(1'b0, 4'd6, 1'b1);
    beat(1'b0, 4'd7, 1'b1);
    checks++;
    if (frame_valid !== 1'b1 || sync_err !== 1'b0 ||
        {ch0, ch1, ch2, ch3} !== 16'hB567 || locked !== 1'b1) begin
      errors++;
      $display("FAIL early_frame: fv=%b serr=%b ch=%h lk=%b expected 1/0/b567/1",
               frame_valid, sync_err, {ch0, ch1, ch2, ch3}, locked);
    end
  endtask

  task automatic test_missing_sync;
    do_reset();
    beat(1'b1, 4'd1, 1'b1);
    beat(1'b0, 4'd2, 1'b1);
    beat(1'b0, 4'd3, 1'b1);
    beat(1'b0, 4'd4, 1'b1);
    beat(1'b0, 4'd5, 1'b1);
    checks++;
    if (sync_err !== 1'b1 || locked !== 1'b1 || sel !== 2'd1) begin
      errors++;
      $display("FAIL miss1: serr=%b lk=%b sel=%0d expected 1/1/1", sync_err, locked, sel);
    end
    beat(1'b0, 4'd6, 1'b1);
    beat(1'b0, 4'd7, 1'b1);
    beat(1'b0, 4'd8, 1'b1);
    checks++;
    if (frame_valid !== 1'b1 || {ch0, ch1, ch2, ch3} !== 16'h5678) begin
      errors++;
      $display("FAIL miss1_frame: fv=%b ch=%h expected 1/5678",
               frame_valid, {ch0, ch1, ch2, ch3});
    end
    beat(1'b0, 4'd9, 1'b1);
    checks++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL miss2: serr=%b lk=%b sel=%0d expected 1/0/0", sync_err, locked, sel);
    end
    beat(1'b0, 4'd1, 1'b1);
    beat(1'b0, 4'd2, 1'b1);
    checks++;
    if (sync_err !== 1'b0 || locked !== 1'b0 || sel !== 2'd0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL hunt_ignore: serr=%b lk=%b sel=%0d fv=%b expected 0/0/0/0",
               sync_err, locked, sel, frame_valid);
    end
  endtask

  task automatic test_reset_midframe;
    do_reset();
    beat(1'b1, 4'd1, 1'b1);
    beat(1'b0, 4'd2, 1'b1);
    beat(1'b0, 4'd3, 1'b1);
    beat(1'b0, 4'd4, 1'b1);
    beat(1'b1, 4'd9, 1'b1);
    beat(1'b0, 4'd10, 1'b1);
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ch0, ch1, ch2, ch3} !== 16'h0 || locked !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: ch=%h lk=%b sel=%0d expected 0000/0/0",
               {ch0, ch1, ch2, ch3}, locked, sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`else
  task automatic test_parity;
    do_reset();
    beat(1'b1, 4'd1, 1'b1);
    beat(1'b0, 4'd2, 1'b1);
    beat(1'b0, 4'd3, 1'b1);
    beat(1'b0, 4'd4, 1'b1);
    beat(1'b0, 4'd4, 1'b1);
    checks++;
    if (frame_valid !== 1'b1 || parity_err !== 1'b0 || {ch0, ch1, ch2, ch3} !== 16'h1234) begin
      errors++;
      $display("FAIL parity_good: fv=%b perr=%b ch=%h expected 1/0/1234",
               frame_valid, parity_err, {ch0, ch1, ch2, ch3});
    end
    beat(1'b1, 4'd8, 1'b1);
    beat(1'b0, 4'd2, 1'b1);
    beat(1'b0, 4'd3, 1'b1);
    beat(1'b0, 4'd4, 1'b1);
    beat(1'b0, 4'd5, 1'b1);
    checks++;
    if (frame_valid !== 1'b0 || parity_err !== 1'b1 || {ch0, ch1, ch2, ch3} !== 16'h1234) begin
      errors++;
      $display("FAIL parity_bad: fv=%b perr=%b ch=%h expected 0/1/1234",
               frame_valid, parity_err, {ch0, ch1, ch2, ch3});
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef TDM_PARITY_EN
    test_normal();
    test_back_to_back();
    test_stalls();
    test_early_sync();
    test_missing_sync();
    test_reset_midframe();
`else
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
- Receive end of a 4-channel time-division-multiplexed link. The transmit end is a 4:1 mux driven by a 2-bit slot counter; this block is the matching 1:4 demultiplexer.
- Locks onto a frame sync marker and steps a slot counter on every valid beat.
- Collects the four slot values into shadow registers, then publishes them together as one frame with a single-cycle strobe.
- Sits between the serial link input and the per-channel consumers.

Parameters:
- WIDTH, 1, bits carried per slot (>=1).
- MISS_LIMIT, 2, consecutive missing sync markers tolerated before lock is dropped (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  slot data.
- din_valid  input  1  din/sync are sampled only when this is 1.
- sync  input  1  marks the first slot of a frame; qualified by din_valid.
- ch0, ch1, ch2, ch3  output  WIDTH each  last complete frame, slots 0..3.
- frame_valid  output  1  one-cycle pulse; ch0..ch3 were updated this cycle.
- sel  output  2  slot index expected for the next valid beat.
- locked  output  1  1 while in LOCKED state.
- sync_err  output  1  one-cycle pulse on a misplaced or missing sync.
- parity_err  output  1  one-cycle pulse on a parity mismatch (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): state=HUNT; ch0..ch3=0; sel=0; frame_valid, locked, sync_err, parity_err=0; shadow regs=0; miss counter=0.
- Beats with din_valid=0 change no state. All pulse outputs are low the cycle after.
- States:
  - HUNT: ignore beats until a beat with sync=1.
    - That beat is slot 0: write shadow0, sel<=1, go LOCKED, locked<=1.
    - sync_err is not raised in HUNT.
  - LOCKED, beat at sel=1..3, sync=0: write shadow[sel], sel<=sel+1 (wraps 3->0).
  - LOCKED, beat at sel=3: in the same edge, load ch0..ch2 from shadow and ch3 from din; frame_valid<=1; sel<=0.
    - Latency: frame_valid and new ch values are visible one cycle after the slot-3 beat is presented.
  - LOCKED, beat at sel=0, sync=1: normal slot 0. Write shadow0, sel<=1, miss counter<=0.
  - LOCKED, beat at sel=0, sync=0 (missing marker): sync_err<=1, miss counter+1.
    - If the counter reaches MISS_LIMIT: go HUNT, locked<=0, sel<=0, counter<=0; beat discarded.
    - Otherwise (flywheel): keep lock, accept the beat as slot 0, sel<=1.
  - LOCKED, beat at sel=1..3, sync=1 (early marker): sync_err<=1, partial frame discarded (no frame_valid).
    - The beat is taken as slot 0: shadow0<=din, sel<=1. Lock kept, miss counter<=0.
- ch0..ch3 hold their value between frames and change only together with frame_valid.
- sync_err and frame_valid are never both 1 from the same beat.
- rst_n asserted mid-frame: partial frame lost; outputs return to reset values immediately.
- Back-to-back frames with din_valid=1 every cycle: one frame_valid every 4 cycles, no bubbles required.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - Frames carry 5 slots and sel counts 0..4. Slot 4 = bitwise XOR of slots 0..3.
  - On the slot-4 beat: if din == XOR(shadow0..3), load ch0..ch3 and pulse frame_valid. Otherwise leave ch unchanged, pulse parity_err, no frame_valid.
  - sel wraps 4->0. An early sync at sel=1..4 behaves as above.
- Not defined: 4-slot frames as in Behaviour; parity_err is tied to 0.

Test Plan:
- Reset: hold rst_n=0 with din=1, sync=1, din_valid=1 -> all outputs 0, locked=0. Release -> first sync beat sets locked=1 next cycle.
- Normal frame, WIDTH=4: beats {sync=1,din=1},{2},{3},{4} with din_valid=1 each cycle -> one cycle after the 4th beat: ch0..ch3=1,2,3,4, frame_valid=1 for exactly one cycle. Repeating frames give frame_valid every 4 cycles.
- Stalls: same frame with din_valid=0 inserted between every beat -> identical ch values; frame_valid only after the 4th valid beat; sel holds during stalls.
- Early sync: sync at sel=2 -> sync_err pulse, no frame_valid. Following beats 5,6,7 complete a frame with ch=(beat value,5,6,7), locked stays 1.
- Missing sync, MISS_LIMIT=2: two consecutive frames without sync at slot 0 -> first gives sync_err and the frame is still delivered; second gives sync_err and locked=0, state HUNT. Beats without sync are then ignored.
- TDM_PARITY_EN: frame 1,2,3,4,parity=4 -> frame_valid. Same data with parity=5 -> parity_err=1, ch unchanged.
